// File: rtl/store_buffer_pkg.sv
// Shared types and op codes for the store buffer slice: ALU op encodings,
// reset level, default depth, drain FSM states and the FIFO entry layout.
package store_buffer_pkg;

    localparam logic       RST_ENABLE      = 1'b1;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam int         STORE_BUF_DEPTH = 4;
    localparam int         ALU_OP_W        = 8;
    localparam int         BYTE_EN_W       = 4;

    localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALU_OP_W-1:0] EXE_SWL_OP = 8'b1110_1010;
    localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [ALU_OP_W-1:0] EXE_SWR_OP = 8'b1110_1110;
    localparam logic [ALU_OP_W-1:0] EXE_SC_OP  = 8'b1111_1000;
    localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } drain_state_t;

    typedef struct packed {
        logic [29:0]          word;
        logic [BYTE_EN_W-1:0] be;
        logic [31:0]          data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fmt.sv
// Combinational store formatter: turns a store op, the low address bits and
// rt into little-endian byte enables and lane-aligned write data.
module store_fmt
    import store_buffer_pkg::*;
(
    input  logic [ALU_OP_W-1:0]  aluop,
    input  logic [1:0]           addr_lo,
    input  logic [31:0]          rt,
    output logic [BYTE_EN_W-1:0] be,
    output logic [31:0]          data,
    output logic                 legal
);

    // Decode op and alignment into byte enables, data lanes and legality
    always_comb begin
        be    = 4'b0000;
        data  = 32'h0000_0000;
        legal = 1'b0;
        case (aluop)
            EXE_SB_OP: begin
                be    = 4'b0001 << addr_lo;
                data  = {4{rt[7:0]}};
                legal = 1'b1;
            end
            EXE_SH_OP: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                data  = {2{rt[15:0]}};
                legal = ~addr_lo[0];
            end
            EXE_SW_OP, EXE_SC_OP: begin
                be    = 4'b1111;
                data  = rt;
                legal = (addr_lo == 2'b00);
            end
            EXE_SWL_OP: begin
                legal = 1'b1;
                case (addr_lo)
                    2'b00:   begin be = 4'b0001; data = {24'h000000, rt[31:24]}; end
                    2'b01:   begin be = 4'b0011; data = {16'h0000, rt[31:16]}; end
                    2'b10:   begin be = 4'b0111; data = {8'h00, rt[31:8]}; end
                    default: begin be = 4'b1111; data = rt; end
                endcase
            end
            EXE_SWR_OP: begin
                legal = 1'b1;
                case (addr_lo)
                    2'b00:   begin be = 4'b1111; data = rt; end
                    2'b01:   begin be = 4'b1110; data = {rt[23:0], 8'h00}; end
                    2'b10:   begin be = 4'b1100; data = {rt[15:0], 16'h0000}; end
                    default: begin be = 4'b1000; data = {rt[7:0], 24'h000000}; end
                endcase
            end
            default: begin
                be    = 4'b0000;
                data  = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: queues formatted stores in a FIFO and drains them
// to the data bus one at a time, flagging loads that hit a pending word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = STORE_BUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st_valid_i,
    input  logic [ALU_OP_W-1:0]  aluop_i,
    input  logic [31:0]          mem_addr_i,
    input  logic [31:0]          reg2_i,
    input  logic                 LLbit_i,
    output logic                 st_ready_o,
    input  logic                 ld_valid_i,
    input  logic [31:0]          ld_addr_i,
    output logic                 ld_hazard_o,
    output logic                 empty_o,
    output logic                 bus_req_o,
    output logic [31:0]          bus_addr_o,
    output logic [31:0]          bus_wdata_o,
    output logic [BYTE_EN_W-1:0] bus_be_o,
    input  logic                 bus_ack_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    sb_entry_t            mem_r [DEPTH];
    logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]        count_r, count_next_s;
    drain_state_t         state_r, state_next_s;
    logic [BYTE_EN_W-1:0] fmt_be_s;
    logic [31:0]          fmt_data_s;
    logic                 fmt_legal_s;
    logic                 enq_s, deq_s, hit_s, in_rst_s;
    logic [PW-1:0]        idx_s;
    sb_entry_t            head_s;

    store_fmt u_fmt (
        .aluop   (aluop_i),
        .addr_lo (mem_addr_i[1:0]),
        .rt      (reg2_i),
        .be      (fmt_be_s),
        .data    (fmt_data_s),
        .legal   (fmt_legal_s)
    );

    assign in_rst_s     = (rst == RST_ENABLE);
    assign st_ready_o   = ~in_rst_s & (count_r < DEPTH_CNT);
    // A full buffer refuses the store even if the head pops this same cycle
    assign enq_s        = st_valid_i & st_ready_o & fmt_legal_s
                        & ~((aluop_i == EXE_SC_OP) & ~LLbit_i);
    assign deq_s        = (state_r == ST_BUSY) & bus_ack_i;
    assign count_next_s = count_r + CW'(enq_s) - CW'(deq_s);
    assign empty_o      = (count_r == {CW{1'b0}});
    assign head_s       = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= enq_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
            rd_ptr_r <= deq_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
            count_r  <= count_next_s;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_r[wr_ptr_r] <= '{word: mem_addr_i[31:2], be: fmt_be_s, data: fmt_data_s};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Drain FSM next state; the head stays on the bus until acknowledged
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CW{1'b0}}) state_next_s = ST_BUSY;
                else                       state_next_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (deq_s) state_next_s = (count_next_s != {CW{1'b0}}) ? ST_BUSY : ST_IDLE;
                else       state_next_s = ST_BUSY;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Bus outputs are driven from the head only while busy
    always_comb begin
        bus_req_o   = 1'b0;
        bus_addr_o  = ZERO_WORD;
        bus_wdata_o = ZERO_WORD;
        bus_be_o    = 4'b0000;
        if (state_r == ST_BUSY) begin
            bus_req_o   = 1'b1;
            bus_addr_o  = {head_s.word, 2'b00};
            bus_wdata_o = head_s.data;
            bus_be_o    = head_s.be;
        end else begin
            bus_req_o   = 1'b0;
        end
    end

    // Word-granular match of the load against every occupied entry
    always_comb begin
        hit_s = 1'b0;
        idx_s = rd_ptr_r;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = rd_ptr_r + PW'(k);
            if ((CW'(k) < count_r) && (mem_r[idx_s].word == ld_addr_i[31:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign ld_hazard_o = ~in_rst_s & ld_valid_i & hit_s;

endmodule
